// File: rtl/i2s_chan_sched.sv
// Round-robin merge of per-channel I2S samples into one tagged stream with overrun counting.
// Optional I2S_SCHED_TIMESTAMP_EN adds a free-running timestamp latched per capture (out_ts).
module i2s_chan_sched #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      adc_clk,
  input  logic                      adc_clk_rst,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH-1:0]         ch_enable,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          drop_count,
  input  logic                      drop_clr,
  output logic [NUM_CH-1:0]         pend
`ifdef I2S_SCHED_TIMESTAMP_EN
  ,
  output logic [31:0]               out_ts
`endif
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned ND_W = CH_W + 1;
  localparam int unsigned CS_W = CNT_W + 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state, state_nx;
  logic                load, unload;
  logic [CH_W-1:0]     rr_ptr, win, idx;
  logic                found;
  logic [NUM_CH-1:0]   elig, cap, gnt, ovr, pend_nx;
  logic [ND_W-1:0]     n_drop;
  logic [CS_W-1:0]     cnt_sum;
  logic [CNT_W-1:0]    cnt_nx;
  logic [DATA_W-1:0]   hold [NUM_CH];

  // Round-robin search from rr_ptr upward over enabled pending channels
  always_comb begin
    elig  = pend & ch_enable;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = rr_ptr + CH_W'(k);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge adc_clk or posedge adc_clk_rst) begin
    if (adc_clk_rst) state <= EMPTY;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unload   = 1'b0;
    case (state)
      EMPTY: begin
        if (found) begin
          load     = 1'b1;
          state_nx = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (found) begin
            load = 1'b1;
          end else begin
            unload   = 1'b1;
            state_nx = EMPTY;
          end
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Capture, disable and overrun bookkeeping; a grant frees the slot for a same-edge capture
  always_comb begin
    cap = ch_valid & ch_enable;
    gnt = '0;
    if (load) gnt[win] = 1'b1;
    ovr     = pend & cap & ~gnt;
    pend_nx = (pend & ch_enable & ~gnt) | cap;
    n_drop  = '0;
    for (int i = 0; i < NUM_CH; i++) n_drop = n_drop + ND_W'(ovr[i]);
    cnt_sum = {1'b0, drop_count} + CS_W'(n_drop);
    if (drop_clr)            cnt_nx = '0;
    else if (cnt_sum[CNT_W]) cnt_nx = '1;
    else                     cnt_nx = cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge adc_clk or posedge adc_clk_rst) begin
    if (adc_clk_rst) begin
      pend       <= '0;
      drop_count <= '0;
      rr_ptr     <= '0;
      out_data   <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      pend       <= pend_nx;
      drop_count <= cnt_nx;
      for (int i = 0; i < NUM_CH; i++)
        if (cap[i]) hold[i] <= ch_data[i*DATA_W +: DATA_W];
      if (load) begin
        out_data  <= hold[win];
        out_ch    <= win;
        out_valid <= 1'b1;
        rr_ptr    <= win + CH_W'(1);
      end else if (unload) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_SCHED_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_hold [NUM_CH];

  always_ff @(posedge adc_clk or posedge adc_clk_rst) begin
    if (adc_clk_rst) begin
      ts_cnt <= '0;
      out_ts <= '0;
      for (int i = 0; i < NUM_CH; i++) ts_hold[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      for (int i = 0; i < NUM_CH; i++)
        if (cap[i]) ts_hold[i] <= ts_cnt;
      if (load) out_ts <= ts_hold[win];
    end
  end
`endif

endmodule

// File: tb/tb_i2s_chan_sched.sv
// Randomised and directed bench for i2s_chan_sched against a cycle-level behavioural model.
module tb_i2s_chan_sched;

  localparam int NCH = 8;
  localparam int DW  = 24;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid, ch_enable;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_ch;
  logic              out_valid, out_ready;
  logic [CW-1:0]     drop_count;
  logic              drop_clr;
  logic [NCH-1:0]    pend;

  int n_tests = 0;
  int n_fail  = 0;

  i2s_chan_sched dut (
    .adc_clk(clk), .adc_clk_rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_enable(ch_enable), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .drop_count(drop_count), .drop_clr(drop_clr), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one pending slot per channel, one output register, fair rotation
  bit          m_pend [NCH];
  logic [23:0] m_hold [NCH];
  bit          m_valid;
  logic [23:0] m_data;
  int          m_ch, m_rr, m_drop;
  int          w, nd;
  bit          fnd, gi, capi;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < NCH; i++) begin m_pend[i] = 0; m_hold[i] = '0; end
        m_valid = 0; m_data = '0; m_ch = 0; m_rr = 0; m_drop = 0;
      end else begin
        fnd = 0; w = 0;
        if (!m_valid || out_ready)
          for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_rr + k) % NCH;
            if (!fnd && m_pend[c] && ch_enable[c]) begin fnd = 1; w = c; end
          end
        if (fnd) begin
          m_data = m_hold[w]; m_ch = w; m_valid = 1; m_rr = (w + 1) % NCH;
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
        nd = 0;
        for (int i = 0; i < NCH; i++) begin
          gi   = fnd && (w == i);
          capi = ch_valid[i] && ch_enable[i];
          if (capi) begin
            if (m_pend[i] && !gi) nd++;
            m_pend[i] = 1;
            m_hold[i] = ch_data[i*DW +: DW];
          end else if (!ch_enable[i] || gi) begin
            m_pend[i] = 0;
          end
        end
        if (drop_clr) m_drop = 0;
        else m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
      end
    end
  end

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("m_valid", 32'(out_valid), 32'(m_valid));
        check("m_pend", 32'(pend), 32'(m_pend_vec()));
        check("m_drop", 32'(drop_count), 32'(m_drop));
        if (m_valid) begin
          check("m_ch", 32'(out_ch), 32'(m_ch));
          check("m_data", 32'(out_data), 32'(m_data));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_all_data(input logic [23:0] base);
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = base + 24'(i);
  endtask

  initial begin
    rst = 1'b1; ch_data = '0; ch_valid = '0; ch_enable = '1; out_ready = 1'b1; drop_clr = 1'b0;
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // single pulse latency
    ch_data[0 +: DW] = 24'h123456; ch_valid = 8'h01;
    step(); ch_valid = '0;
    check("lat_pend", 32'(pend), 32'h01);
    check("lat_idle", 32'(out_valid), 32'd0);
    step();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_ch", 32'(out_ch), 32'd0);
    check("lat_data", 32'(out_data), 32'h123456);
    check("lat_pend0", 32'(pend), 32'd0);
    step();
    check("lat_pulse1", 32'(out_valid), 32'd0);

    // all channels at once drain in order
    do_reset();
    set_all_data(24'd0); ch_valid = '1;
    step(); ch_valid = '0;
    check("all_pend", 32'(pend), 32'hFF);
    for (int j = 0; j < NCH; j++) begin
      step();
      check("all_valid", 32'(out_valid), 32'd1);
      check("all_ch", 32'(out_ch), 32'(j));
      check("all_data", 32'(out_data), 32'(j));
    end
    step();
    check("all_done", 32'(out_valid), 32'd0);
    check("all_drop", 32'(drop_count), 32'd0);
    ch_valid = 8'h81;
    step(); ch_valid = '0;
    step();
    check("wrap_ch0", 32'(out_ch), 32'd0);
    step();
    check("wrap_ch7", 32'(out_ch), 32'd7);
    step();

    // backpressure with overwrite
    do_reset();
    out_ready = 1'b0;
    ch_data[3*DW +: DW] = 24'hAAAAAA; ch_valid = 8'h08;
    step(); ch_valid = '0;
    step();
    check("bp_ch", 32'(out_ch), 32'd3);
    check("bp_dataA", 32'(out_data), 32'hAAAAAA);
    ch_data[3*DW +: DW] = 24'hBBBBBB; ch_valid = 8'h08;
    step();
    check("bp_pend", 32'(pend), 32'h08);
    ch_data[3*DW +: DW] = 24'hCCCCCC;
    step(); ch_valid = '0;
    check("bp_drop", 32'(drop_count), 32'd1);
    step();
    check("bp_hold", 32'(out_data), 32'hAAAAAA);
    check("bp_hold_v", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_dataC", 32'(out_data), 32'hCCCCCC);
    check("bp_pend0", 32'(pend), 32'd0);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // fairness between two busy channels
    do_reset();
    for (int n = 0; n < 10; n++) begin
      ch_data[1*DW +: DW] = 24'($urandom); ch_data[5*DW +: DW] = 24'($urandom);
      ch_valid = 8'h22;
      step();
      if (n >= 1) check("fair_ch", 32'(out_ch), (n % 2 == 1) ? 32'd1 : 32'd5);
    end
    ch_valid = '0;
    repeat (3) step();

    // mask, saturation, clear
    do_reset();
    ch_enable = 8'hFE; ch_valid = 8'h01;
    step(); ch_valid = '0;
    check("mask_pend", 32'(pend), 32'd0);
    step();
    check("mask_idle", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    for (int n = 0; n < 9500; n++) begin
      set_all_data(24'($urandom)); ch_valid = '1;
      step();
    end
    check("sat_drop", 32'(drop_count), 32'hFFFF);
    check("sat_ch", 32'(out_ch), 32'd1);
    drop_clr = 1'b1;
    step();
    check("clr_drop", 32'(drop_count), 32'd0);
    drop_clr = 1'b0; ch_valid = '0; ch_enable = '1; out_ready = 1'b1;
    repeat (10) step();

    // async reset mid-burst
    do_reset();
    out_ready = 1'b0; ch_valid = 8'h50;
    step(); ch_valid = '0;
    step();
    check("ar_full", 32'(out_valid), 32'd1);
    check("ar_ch4", 32'(out_ch), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_pend", 32'(pend), 32'd0);
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1; ch_valid = 8'h24;
    step(); ch_valid = '0;
    step();
    check("ar_first", 32'(out_ch), 32'd2);
    step();
    check("ar_second", 32'(out_ch), 32'd5);
    step();

    // randomised traffic
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (n % 64 == 0) ch_enable = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      set_all_data(24'($urandom));
      for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = 24'($urandom);
      ch_valid  = 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      drop_clr  = ($urandom_range(0, 63) == 0);
      step();
    end
    ch_valid = '0; drop_clr = 1'b0; out_ready = 1'b1;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
